pe_tile_sequencer: RTL and testbench
====================================

// Module: pe_tile_sequencer
// PURPOSE
// Parametrised load/compute sequencer for the MBConv PE cluster. Streams weights into NUM_PE weight
// BRAM banks and IFM words into the IFM BRAM, then issues read addresses and per-window PE
// reset/finish strobes for every window of every tile. Replaces the fixed 16-lane control/addr-gen
// path; adds variable lane count, weight reuse across runs and a ready/valid load stream.
// PARAMETERS
// NUM_PE   16  PE lanes = weight banks
// DATA_W   32  stream/BRAM word width (4 packed int8)
// ADDR_W   20  BRAM address width, IFM and weight
// CNT_W    16  width of every config count
// RD_LAT   1   BRAM read latency in cycles; strobes delayed to match
// PORTS
// clk            in   1          clock, all logic rising-edge
// rst_n          in   1          async active-low reset
// start          in   1          begin a run; accepted only in IDLE
// cfg_skip_wload in   1          1 = keep banks, skip LOAD_W
// cfg_w_words    in   CNT_W      words per weight bank (>=1)
// cfg_ifm_words  in   CNT_W      IFM words to load (>=1)
// cfg_win_len    in   CNT_W      reads per window (>=1)
// cfg_win_stride in   CNT_W      IFM address step between windows
// cfg_num_win    in   CNT_W      windows per tile (>=1)
// cfg_num_tiles  in   CNT_W      tiles per run (>=1)
// s_valid        in   1          load word valid
// s_ready        out  1          load word accepted when s_valid&s_ready
// s_data         in   DATA_W     load word
// w_wr_en        out  NUM_PE     one-hot weight-bank write enable
// ifm_wr_en      out  1          IFM write enable
// wr_addr        out  ADDR_W     write address, shared
// wr_data        out  DATA_W     write data, = s_data registered
// ifm_rd_addr    out  ADDR_W     IFM read address
// w_rd_addr      out  ADDR_W     weight read address, broadcast to all banks
// pe_reset       out  1          clear accumulators, aligned to first read data of window
// pe_finish      out  1          window result valid, aligned to last read data of window
// tile_idx       out  CNT_W      current tile
// busy           out  1          state != IDLE
// done           out  1          one-cycle pulse at run end
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE; bank contents unaffected. Reset mid-run aborts to IDLE, no done.
// - cfg_* sampled into registers on accepted start; ignored until next IDLE.
// - States: IDLE -> LOAD_W -> LOAD_IFM -> COMPUTE -> DRAIN -> IDLE.
//   IDLE: start -> LOAD_W, or LOAD_IFM if cfg_skip_wload.
// - LOAD_W: s_ready=1. Words fill bank 0 addr 0..w_words-1, then bank 1, ... bank NUM_PE-1.
//   Write registered: w_wr_en/wr_addr/wr_data valid the cycle after the handshake. s_valid=0 stalls.
//   After NUM_PE*w_words handshakes -> LOAD_IFM.
// - LOAD_IFM: same rules, ifm_wr_en, addr 0..ifm_words-1; last handshake -> COMPUTE. s_ready=0 elsewhere.
// - COMPUTE: one read per cycle, no stalls. Counters off (0..win_len-1), win, tile.
//   ifm_rd_addr = win*win_stride + off; w_rd_addr = tile*win_len + off (ADDR_W-bit, wrap modulo).
//   off wraps -> win++; win wraps -> tile++; last read of last tile -> DRAIN.
// - pe_reset = (off==0) delayed RD_LAT+1 cycles; pe_finish = (off==win_len-1) delayed RD_LAT+1.
//   win_len=1: both assert same cycle, every cycle.
// - DRAIN: wait RD_LAT+1 cycles for last pe_finish, then done=1 one cycle, -> IDLE.
// - tile_idx follows the read side (not delayed). start while busy ignored.
// - Total COMPUTE cycles = win_len*num_win*num_tiles; pe_finish pulses = num_win*num_tiles.
// TESTING
// - NUM_PE=4, w_words=2, ifm_words=3, all s_valid=1 -> banks 0..3 get words 0-7 in order, IFM gets 8-10, COMPUTE 1 cycle after last.
// - win_len=3, win_stride=2, num_win=2, num_tiles=2 -> ifm_rd 0,1,2,2,3,4,0,1,2,2,3,4; w_rd 0,1,2,0,1,2,3,4,5,3,4,5; 4 pe_finish; done once.
// - s_valid toggled 1,0,1,0 during LOAD_W -> writes only on handshakes, address sequence unchanged.
// - cfg_skip_wload=1 -> no w_wr_en pulse; first handshake writes IFM addr 0.
// - win_len=1, num_win=3, num_tiles=1, RD_LAT=1 -> pe_reset=pe_finish=1 for 3 consecutive cycles, starting 2 cycles after first read.
// - rst_n low mid-COMPUTE -> all outputs 0 immediately, no done; fresh start runs full sequence.

Source files
------------

// File: rtl/pe_tile_sequencer_if.sv
// Load-stream handshake bundle for pe_tile_sequencer: the producer drives
// valid/data, the sequencer answers with ready.
interface pe_tile_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );
endinterface

// File: rtl/pe_tile_sequencer.sv
// Load/compute sequencer for the MBConv PE cluster: fills NUM_PE weight banks and the
// IFM bank from a ready/valid stream, then walks every window of every tile.
module pe_tile_sequencer #(
  parameter int NUM_PE = 16,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 20,
  parameter int CNT_W  = 16,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 cfg_skip_wload,
  input  logic [CNT_W-1:0]     cfg_w_words,
  input  logic [CNT_W-1:0]     cfg_ifm_words,
  input  logic [CNT_W-1:0]     cfg_win_len,
  input  logic [CNT_W-1:0]     cfg_win_stride,
  input  logic [CNT_W-1:0]     cfg_num_win,
  input  logic [CNT_W-1:0]     cfg_num_tiles,
  pe_tile_sequencer_if.slave   ld,
  output logic [NUM_PE-1:0]    w_wr_en,
  output logic                 ifm_wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic [ADDR_W-1:0]    ifm_rd_addr,
  output logic [ADDR_W-1:0]    w_rd_addr,
  output logic                 pe_reset,
  output logic                 pe_finish,
  output logic [CNT_W-1:0]     tile_idx,
  output logic                 busy,
  output logic                 done
);

  localparam int BANK_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int DRN_W  = $clog2(RD_LAT + 1) + 1;
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);
  localparam logic [NUM_PE-1:0] BANK0_OH  = NUM_PE'(1);
  localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(NUM_PE - 1);
  localparam logic [DRN_W-1:0]  DRN_LAST  = DRN_W'(RD_LAT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_W   = 3'd1,
    LOAD_IFM = 3'd2,
    COMPUTE  = 3'd3,
    DRAIN    = 3'd4
  } state_t;

  state_t state_r, state_nx_s;

  logic [CNT_W-1:0]  w_words_r, ifm_words_r, win_len_r, stride_r, num_win_r, num_tiles_r;
  logic [CNT_W-1:0]  ld_addr_r;
  logic [BANK_W-1:0] bank_r;
  logic [CNT_W-1:0]  off_r, win_r, tile_r;
  logic [ADDR_W-1:0] win_base_r, tile_base_r;
  logic [DRN_W-1:0]  drain_r;
  logic [RD_LAT:0]   rst_pipe_r, fin_pipe_r;

  logic              s_ready_r;
  logic [NUM_PE-1:0] w_wr_en_r;
  logic              ifm_wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [DATA_W-1:0] wr_data_r;
  logic [ADDR_W-1:0] ifm_rd_addr_r, w_rd_addr_r;
  logic [CNT_W-1:0]  tile_idx_r;
  logic              busy_r, done_r;

  logic hs_s, ld_last_s, bank_last_s, off_last_s, win_last_s, tile_last_s, drain_last_s;

  assign hs_s         = s_ready_r & ld.s_valid;
  assign bank_last_s  = (bank_r == BANK_LAST);
  assign off_last_s   = (off_r == win_len_r - CNT_ONE);
  assign win_last_s   = (win_r == num_win_r - CNT_ONE);
  assign tile_last_s  = (tile_r == num_tiles_r - CNT_ONE);
  assign drain_last_s = (drain_r == DRN_LAST);

  // Last-address detect for whichever bank type is currently being loaded.
  always_comb begin
    ld_last_s = 1'b0;
    if (state_r == LOAD_W) begin
      ld_last_s = (ld_addr_r == w_words_r - CNT_ONE);
    end else begin
      ld_last_s = (ld_addr_r == ifm_words_r - CNT_ONE);
    end
  end

  // Next-state logic for the run sequence.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = cfg_skip_wload ? LOAD_IFM : LOAD_W;
        end else begin
          state_nx_s = IDLE;
        end
      end
      LOAD_W: begin
        if (hs_s && ld_last_s && bank_last_s) begin
          state_nx_s = LOAD_IFM;
        end else begin
          state_nx_s = LOAD_W;
        end
      end
      LOAD_IFM: begin
        if (hs_s && ld_last_s) begin
          state_nx_s = COMPUTE;
        end else begin
          state_nx_s = LOAD_IFM;
        end
      end
      COMPUTE: begin
        if (off_last_s && win_last_s && tile_last_s) begin
          state_nx_s = DRAIN;
        end else begin
          state_nx_s = COMPUTE;
        end
      end
      DRAIN: begin
        if (drain_last_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DRAIN;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register plus the state-derived handshake/status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      s_ready_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      drain_r   <= {DRN_W{1'b0}};
    end else begin
      state_r   <= state_nx_s;
      s_ready_r <= (state_nx_s == LOAD_W) || (state_nx_s == LOAD_IFM);
      busy_r    <= (state_nx_s != IDLE);
      done_r    <= (state_r == DRAIN) && drain_last_s;
      drain_r   <= (state_r == DRAIN) ? drain_r + DRN_W'(1) : {DRN_W{1'b0}};
    end
  end

  // Run configuration is frozen on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_words_r   <= CNT_ZERO;
      ifm_words_r <= CNT_ZERO;
      win_len_r   <= CNT_ZERO;
      stride_r    <= CNT_ZERO;
      num_win_r   <= CNT_ZERO;
      num_tiles_r <= CNT_ZERO;
    end else if ((state_r == IDLE) && start) begin
      w_words_r   <= cfg_w_words;
      ifm_words_r <= cfg_ifm_words;
      win_len_r   <= cfg_win_len;
      stride_r    <= cfg_win_stride;
      num_win_r   <= cfg_num_win;
      num_tiles_r <= cfg_num_tiles;
    end
  end

  // Load path: each handshake becomes a registered bank write one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_addr_r   <= CNT_ZERO;
      bank_r      <= {BANK_W{1'b0}};
      w_wr_en_r   <= {NUM_PE{1'b0}};
      ifm_wr_en_r <= 1'b0;
      wr_addr_r   <= ADDR_ZERO;
      wr_data_r   <= {DATA_W{1'b0}};
    end else begin
      w_wr_en_r   <= {NUM_PE{1'b0}};
      ifm_wr_en_r <= 1'b0;
      if (state_r == IDLE) begin
        ld_addr_r <= CNT_ZERO;
        bank_r    <= {BANK_W{1'b0}};
      end else if (hs_s) begin
        wr_addr_r <= ADDR_W'(ld_addr_r);
        wr_data_r <= ld.s_data;
        if (state_r == LOAD_W) begin
          w_wr_en_r <= BANK0_OH << bank_r;
        end else begin
          ifm_wr_en_r <= 1'b1;
        end
        if (ld_last_s) begin
          ld_addr_r <= CNT_ZERO;
          if (state_r == LOAD_W) begin
            bank_r <= bank_last_s ? {BANK_W{1'b0}} : bank_r + BANK_W'(1);
          end
        end else begin
          ld_addr_r <= ld_addr_r + CNT_ONE;
        end
      end
    end
  end

  // Window/tile walk; bases accumulate so no multiplier is needed for the address math.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_r         <= CNT_ZERO;
      win_r         <= CNT_ZERO;
      tile_r        <= CNT_ZERO;
      win_base_r    <= ADDR_ZERO;
      tile_base_r   <= ADDR_ZERO;
      ifm_rd_addr_r <= ADDR_ZERO;
      w_rd_addr_r   <= ADDR_ZERO;
      tile_idx_r    <= CNT_ZERO;
    end else if (state_r == COMPUTE) begin
      ifm_rd_addr_r <= win_base_r + ADDR_W'(off_r);
      w_rd_addr_r   <= tile_base_r + ADDR_W'(off_r);
      tile_idx_r    <= tile_r;
      if (!off_last_s) begin
        off_r <= off_r + CNT_ONE;
      end else begin
        off_r <= CNT_ZERO;
        if (!win_last_s) begin
          win_r      <= win_r + CNT_ONE;
          win_base_r <= win_base_r + ADDR_W'(stride_r);
        end else begin
          win_r      <= CNT_ZERO;
          win_base_r <= ADDR_ZERO;
          if (!tile_last_s) begin
            tile_r      <= tile_r + CNT_ONE;
            tile_base_r <= tile_base_r + ADDR_W'(win_len_r);
          end
        end
      end
    end else begin
      ifm_rd_addr_r <= ADDR_ZERO;
      w_rd_addr_r   <= ADDR_ZERO;
      if (state_r == IDLE) begin
        off_r       <= CNT_ZERO;
        win_r       <= CNT_ZERO;
        tile_r      <= CNT_ZERO;
        win_base_r  <= ADDR_ZERO;
        tile_base_r <= ADDR_ZERO;
        tile_idx_r  <= CNT_ZERO;
      end
    end
  end

  // Strobes ride a RD_LAT+1 pipe: one stage for the address register, RD_LAT for the BRAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_pipe_r <= {(RD_LAT + 1){1'b0}};
      fin_pipe_r <= {(RD_LAT + 1){1'b0}};
    end else begin
      rst_pipe_r[0] <= (state_r == COMPUTE) && (off_r == CNT_ZERO);
      fin_pipe_r[0] <= (state_r == COMPUTE) && off_last_s;
      for (int i = 1; i <= RD_LAT; i++) begin
        rst_pipe_r[i] <= rst_pipe_r[i-1];
        fin_pipe_r[i] <= fin_pipe_r[i-1];
      end
    end
  end

  assign ld.s_ready  = s_ready_r;
  assign w_wr_en     = w_wr_en_r;
  assign ifm_wr_en   = ifm_wr_en_r;
  assign wr_addr     = wr_addr_r;
  assign wr_data     = wr_data_r;
  assign ifm_rd_addr = ifm_rd_addr_r;
  assign w_rd_addr   = w_rd_addr_r;
  assign pe_reset    = rst_pipe_r[RD_LAT];
  assign pe_finish   = fin_pipe_r[RD_LAT];
  assign tile_idx    = tile_idx_r;
  assign busy        = busy_r;
  assign done        = done_r;

endmodule

// File: tb/tb_pe_tile_sequencer.sv
// Directed bench for pe_tile_sequencer (NUM_PE=4, RD_LAT=1): load ordering, stalls,
// weight reuse, window/tile address walk, strobe alignment and mid-run reset.
module tb_pe_tile_sequencer;
  localparam int NUM_PE = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 20;
  localparam int CNT_W  = 16;
  localparam int RD_LAT = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cfg_skip_wload = 1'b0;
  logic [CNT_W-1:0] cfg_w_words = '0, cfg_ifm_words = '0, cfg_win_len = '0;
  logic [CNT_W-1:0] cfg_win_stride = '0, cfg_num_win = '0, cfg_num_tiles = '0;
  logic [NUM_PE-1:0] w_wr_en;
  logic ifm_wr_en, pe_reset, pe_finish, busy, done;
  logic [ADDR_W-1:0] wr_addr, ifm_rd_addr, w_rd_addr;
  logic [DATA_W-1:0] wr_data;
  logic [CNT_W-1:0] tile_idx;

  int n_checks = 0;
  int n_errors = 0;
  int exp_ifm [16];
  int exp_w   [16];
  int exp_tile[16];

  pe_tile_sequencer_if #(.DATA_W(DATA_W)) ld_if ();

  always #5 clk = ~clk;

  pe_tile_sequencer #(
    .NUM_PE(NUM_PE), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_skip_wload(cfg_skip_wload),
    .cfg_w_words(cfg_w_words), .cfg_ifm_words(cfg_ifm_words), .cfg_win_len(cfg_win_len),
    .cfg_win_stride(cfg_win_stride), .cfg_num_win(cfg_num_win), .cfg_num_tiles(cfg_num_tiles),
    .ld(ld_if.slave), .w_wr_en(w_wr_en), .ifm_wr_en(ifm_wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .ifm_rd_addr(ifm_rd_addr), .w_rd_addr(w_rd_addr),
    .pe_reset(pe_reset), .pe_finish(pe_finish), .tile_idx(tile_idx), .busy(busy), .done(done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".w_wr_en"}, 32'(w_wr_en), 32'd0);
    chk({tag, ".ifm_wr_en"}, 32'(ifm_wr_en), 32'd0);
    chk({tag, ".wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, ".wr_data"}, wr_data, 32'd0);
    chk({tag, ".ifm_rd_addr"}, 32'(ifm_rd_addr), 32'd0);
    chk({tag, ".w_rd_addr"}, 32'(w_rd_addr), 32'd0);
    chk({tag, ".pe_reset"}, 32'(pe_reset), 32'd0);
    chk({tag, ".pe_finish"}, 32'(pe_finish), 32'd0);
    chk({tag, ".tile_idx"}, 32'(tile_idx), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".s_ready"}, 32'(ld_if.s_ready), 32'd0);
  endtask

  task automatic set_cfg(input logic skip, input int ww, input int iw, input int wl,
                         input int st, input int nw, input int nt);
    cfg_skip_wload = skip;
    cfg_w_words    = CNT_W'(ww);
    cfg_ifm_words  = CNT_W'(iw);
    cfg_win_len    = CNT_W'(wl);
    cfg_win_stride = CNT_W'(st);
    cfg_num_win    = CNT_W'(nw);
    cfg_num_tiles  = CNT_W'(nt);
  endtask

  // Starts on the cycle after the last load handshake; n reads, window length wl.
  task automatic check_compute(input string tag, input int n, input int wl);
    for (int j = 0; j <= n + 2; j++) begin
      step();
      if (j < n) begin
        chk($sformatf("%s.ifm_rd[%0d]", tag, j), 32'(ifm_rd_addr), 32'(exp_ifm[j]));
        chk($sformatf("%s.w_rd[%0d]", tag, j), 32'(w_rd_addr), 32'(exp_w[j]));
        chk($sformatf("%s.tile[%0d]", tag, j), 32'(tile_idx), 32'(exp_tile[j]));
      end
      chk($sformatf("%s.pe_reset[%0d]", tag, j), 32'(pe_reset),
          32'((j >= 1 && j <= n && ((j - 1) % wl) == 0) ? 1 : 0));
      chk($sformatf("%s.pe_finish[%0d]", tag, j), 32'(pe_finish),
          32'((j >= 1 && j <= n && ((j - 1) % wl) == wl - 1) ? 1 : 0));
      chk($sformatf("%s.done[%0d]", tag, j), 32'(done), 32'((j == n + 1) ? 1 : 0));
      chk($sformatf("%s.busy[%0d]", tag, j), 32'(busy), 32'((j <= n) ? 1 : 0));
    end
  endtask

  initial begin
    ld_if.s_valid = 1'b0;
    ld_if.s_data  = '0;
    #1;
    chk_all_zero("reset");
    step();
    step();
    rst_n = 1'b1;
    step();
    chk_all_zero("idle");

    // Run A: full load then 2 tiles x 2 windows x 3 reads.
    set_cfg(1'b0, 2, 3, 3, 2, 2, 2);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("A.s_ready", 32'(ld_if.s_ready), 32'd1);
    chk("A.busy", 32'(busy), 32'd1);
    set_cfg(1'b1, 7, 7, 5, 9, 9, 9);
    ld_if.s_valid = 1'b1;
    ld_if.s_data  = 32'd0;
    for (int k = 0; k < 11; k++) begin
      step();
      if (k < 8) begin
        chk($sformatf("A.w_wr_en[%0d]", k), 32'(w_wr_en), 32'(1 << (k / 2)));
        chk($sformatf("A.ifm_wr_en[%0d]", k), 32'(ifm_wr_en), 32'd0);
        chk($sformatf("A.wr_addr[%0d]", k), 32'(wr_addr), 32'(k % 2));
      end else begin
        chk($sformatf("A.w_wr_en[%0d]", k), 32'(w_wr_en), 32'd0);
        chk($sformatf("A.ifm_wr_en[%0d]", k), 32'(ifm_wr_en), 32'd1);
        chk($sformatf("A.wr_addr[%0d]", k), 32'(wr_addr), 32'(k - 8));
      end
      chk($sformatf("A.wr_data[%0d]", k), wr_data, 32'(k));
      start = (k == 4);
      ld_if.s_data = 32'(k + 1);
    end
    start = 1'b0;
    ld_if.s_valid = 1'b0;
    chk("A.s_ready_compute", 32'(ld_if.s_ready), 32'd0);
    exp_ifm  = '{0, 1, 2, 2, 3, 4, 0, 1, 2, 2, 3, 4, 0, 0, 0, 0};
    exp_w    = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5, 0, 0, 0, 0};
    exp_tile = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    check_compute("A", 12, 3);

    // Run B: stalled weight load (1 word per bank), then win_len=1 x 3 windows.
    set_cfg(1'b0, 1, 1, 1, 1, 3, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    ld_if.s_valid = 1'b1;
    ld_if.s_data  = 32'd100;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i % 2 == 0) begin
        chk($sformatf("B.w_wr_en[%0d]", i), 32'(w_wr_en), 32'(1 << (i / 2)));
        chk($sformatf("B.wr_addr[%0d]", i), 32'(wr_addr), 32'd0);
        chk($sformatf("B.wr_data[%0d]", i), wr_data, 32'(100 + i / 2));
      end else begin
        chk($sformatf("B.w_wr_en_stall[%0d]", i), 32'(w_wr_en), 32'd0);
      end
      ld_if.s_valid = ((i + 1) % 2 == 0);
      ld_if.s_data  = 32'(100 + (i + 1) / 2);
    end
    ld_if.s_data = 32'd200;
    step();
    ld_if.s_valid = 1'b0;
    chk("B.ifm_wr_en", 32'(ifm_wr_en), 32'd1);
    chk("B.ifm_wr_addr", 32'(wr_addr), 32'd0);
    chk("B.ifm_wr_data", wr_data, 32'd200);
    chk("B.s_ready_compute", 32'(ld_if.s_ready), 32'd0);
    exp_ifm  = '{0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_w    = '{default: 0};
    exp_tile = '{default: 0};
    check_compute("B", 3, 1);

    // Run C: weight reuse, reset in the middle of COMPUTE, then a clean rerun.
    set_cfg(1'b1, 1, 2, 2, 1, 2, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("C.s_ready", 32'(ld_if.s_ready), 32'd1);
    ld_if.s_valid = 1'b1;
    ld_if.s_data  = 32'd300;
    step();
    chk("C.w_wr_en_skip", 32'(w_wr_en), 32'd0);
    chk("C.ifm_wr_en0", 32'(ifm_wr_en), 32'd1);
    chk("C.ifm_addr0", 32'(wr_addr), 32'd0);
    ld_if.s_data = 32'd301;
    step();
    ld_if.s_valid = 1'b0;
    chk("C.ifm_addr1", 32'(wr_addr), 32'd1);
    chk("C.ifm_data1", wr_data, 32'd301);
    step();
    chk("C.ifm_rd0", 32'(ifm_rd_addr), 32'd0);
    step();
    chk("C.ifm_rd1", 32'(ifm_rd_addr), 32'd1);
    chk("C.pe_reset_pre", 32'(pe_reset), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("C.abort");
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("C.no_done[%0d]", i), 32'(done), 32'd0);
      chk($sformatf("C.no_busy[%0d]", i), 32'(busy), 32'd0);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    ld_if.s_valid = 1'b1;
    ld_if.s_data  = 32'd400;
    step();
    chk("C2.w_wr_en_skip", 32'(w_wr_en), 32'd0);
    chk("C2.ifm_addr0", 32'(wr_addr), 32'd0);
    ld_if.s_data = 32'd401;
    step();
    ld_if.s_valid = 1'b0;
    chk("C2.ifm_addr1", 32'(wr_addr), 32'd1);
    exp_ifm = '{0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_w   = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    check_compute("C2", 4, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
